// File: rtl/pipeline_phase_pkg.sv
// Shared definitions for the 5-phase pipeline sequencer.
//   PH_IF..PH_WB : one-hot phasecounter values
//   state_t      : sequencer FSM encoding (ST_HALTED / ST_RUN)
//   NOP_INSTR    : instruction word loaded into IFID on a bubble
package pipeline_phase_pkg;

  localparam int NUM_PHASES = 5;

  localparam logic [4:0] PH_IF  = 5'b00001;
  localparam logic [4:0] PH_ID  = 5'b00010;
  localparam logic [4:0] PH_EX  = 5'b00100;
  localparam logic [4:0] PH_MEM = 5'b01000;
  localparam logic [4:0] PH_WB  = 5'b10000;

  typedef enum logic {
    ST_HALTED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_phase_sequencer_phase_ring.sv
// phase_ring: 5-bit one-hot phase rotator.
//   clock, reset : clock and synchronous active-high reset (resets to PH_IF)
//   advance      : rotate one position this cycle
//   hold         : freeze the current phase (overrides advance)
//   force_if     : jump back to PH_IF (overrides everything else)
//   phase        : registered one-hot phase
// Only PH_IF or a rotation of the current value is ever loaded, so the
// register stays one-hot.
module phase_ring
  import pipeline_phase_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  input  logic       hold,
  input  logic       force_if,
  output logic [4:0] phase
);

  logic [4:0] phase_reg;
  logic [4:0] phase_next;

  // Rotate left: bit gi takes the previous phase bit, WB wraps into IF.
  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_rot
      assign phase_next[gi] = phase_reg[(gi + NUM_PHASES - 1) % NUM_PHASES];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg <= PH_IF;
    end else if (force_if) begin
      phase_reg <= PH_IF;
    end else if (advance && !hold) begin
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/pipeline_phase_sequencer.sv
// pipeline_phase_sequencer: master sequencer for the 5-phase pipelined core.
//   clock, reset            : clock, synchronous active-high reset
//   start                   : pulse, leave HALTED and run
//   step_en / halt_req      : halt at the end of the WB phase
//   mem_busy                : hold the MEM phase (watchdog guarded)
//   flush_req               : branch taken, sampled during EX
//   phasecounter            : one-hot phase [0]IF [1]ID [2]EX [3]MEM [4]WB
//   latch_* / bubble_*      : pipeline register load strobes and NOP inserts
//   running / halted        : FSM state flags
//   stall_timeout           : sticky watchdog expiry flag
//   retired                 : saturating count of completed WB phases
module pipeline_phase_sequencer
  import pipeline_phase_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step_en,
  input  logic             halt_req,
  input  logic             mem_busy,
  input  logic             flush_req,
  output logic [4:0]       phasecounter,
  output logic             latch_ifid,
  output logic             latch_idex,
  output logic             latch_exmem,
  output logic             latch_memwb,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             running,
  output logic             halted,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int STALL_W = $clog2(MAX_STALL + 1);
  // Value held by the counter during the MAX_STALL-th consecutive stall.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);

  state_t             state_reg;
  logic               running_reg;
  logic               halted_reg;
  logic               stall_timeout_reg;
  logic               flush_pending_reg;
  logic [STALL_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0]   retired_reg;

  logic stalled;
  logic wb_cycle;
  logic wb_halt;
  logic expiry;

  assign stalled  = running_reg & phasecounter[3] & mem_busy;
  assign wb_cycle = running_reg & phasecounter[4];
  assign wb_halt  = wb_cycle & (halt_req | step_en);
  assign expiry   = stalled & (stall_cnt_reg == STALL_LAST);

  phase_ring u_phase_ring (
    .clock    (clock),
    .reset    (reset),
    .advance  (running_reg),
    .hold     (stalled),
    .force_if (wb_halt | expiry),
    .phase    (phasecounter)
  );

  // Run/halt FSM with registered state flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_HALTED;
      running_reg       <= 1'b0;
      halted_reg        <= 1'b1;
      stall_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_HALTED: begin
          if (start) begin
            state_reg         <= ST_RUN;
            running_reg       <= 1'b1;
            halted_reg        <= 1'b0;
            stall_timeout_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (wb_halt || expiry) begin
            state_reg   <= ST_HALTED;
            running_reg <= 1'b0;
            halted_reg  <= 1'b1;
          end
          if (expiry) begin
            stall_timeout_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_HALTED;
          running_reg <= 1'b0;
          halted_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Watchdog, retirement counter and flush tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg     <= '0;
      retired_reg       <= '0;
      flush_pending_reg <= 1'b0;
    end else begin
      if (stalled && !expiry) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end else begin
        stall_cnt_reg <= '0;
      end

      if (wb_cycle && (retired_reg != {CNT_W{1'b1}})) begin
        retired_reg <= retired_reg + 1'b1;
      end

      // Pending flush covers the IF and ID phases that follow the branch.
      if (expiry) begin
        flush_pending_reg <= 1'b0;
      end else if (running_reg && phasecounter[2] && flush_req) begin
        flush_pending_reg <= 1'b1;
      end else if (running_reg && phasecounter[1]) begin
        flush_pending_reg <= 1'b0;
      end
    end
  end

  assign latch_ifid    = running_reg & phasecounter[0];
  assign latch_idex    = running_reg & phasecounter[1];
  assign latch_exmem   = running_reg & phasecounter[2];
  assign latch_memwb   = running_reg & phasecounter[3] & ~mem_busy;
  assign bubble_ifid   = flush_pending_reg & latch_ifid;
  assign bubble_idex   = flush_pending_reg & latch_idex;
  assign running       = running_reg;
  assign halted        = halted_reg;
  assign stall_timeout = stall_timeout_reg;
  assign retired       = retired_reg;

endmodule

// File: tb/tb_pipeline_phase_sequencer.sv
module tb_pipeline_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        step_en;
  logic        halt_req;
  logic        mem_busy;
  logic        flush_req;
  logic [4:0]  phasecounter;
  logic        latch_ifid;
  logic        latch_idex;
  logic        latch_exmem;
  logic        latch_memwb;
  logic        bubble_ifid;
  logic        bubble_idex;
  logic        running;
  logic        halted;
  logic        stall_timeout;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipeline_phase_sequencer #(
    .CNT_W     (16),
    .MAX_STALL (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .step_en       (step_en),
    .halt_req      (halt_req),
    .mem_busy      (mem_busy),
    .flush_req     (flush_req),
    .phasecounter  (phasecounter),
    .latch_ifid    (latch_ifid),
    .latch_idex    (latch_idex),
    .latch_exmem   (latch_exmem),
    .latch_memwb   (latch_memwb),
    .bubble_ifid   (bubble_ifid),
    .bubble_idex   (bubble_idex),
    .running       (running),
    .halted        (halted),
    .stall_timeout (stall_timeout),
    .retired       (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {latch_memwb, latch_exmem, latch_idex, latch_ifid};
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_phase"},   32'(phasecounter),  32'h01);
    check_eq({tag, "_latch"},   32'(strobes()),     32'h0);
    check_eq({tag, "_bubble"},  32'({bubble_idex, bubble_ifid}), 32'h0);
    check_eq({tag, "_halted"},  32'(halted),        32'h1);
    check_eq({tag, "_running"}, 32'(running),       32'h0);
    check_eq({tag, "_tmo"},     32'(stall_timeout), 32'h0);
    check_eq({tag, "_retired"}, 32'(retired),       32'h0);
  endtask

  logic [4:0] exp_ph [5] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
  logic [3:0] exp_lt [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  initial begin
    reset = 1'b1; start = 1'b0; step_en = 1'b0; halt_req = 1'b0;
    mem_busy = 1'b0; flush_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_state("rst");

    // 1: free run, one strobe per cycle
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t1_phase%0d", i), 32'(phasecounter), 32'(exp_ph[i]));
      check_eq($sformatf("t1_latch%0d", i), 32'(strobes()), 32'(exp_lt[i]));
      tick();
    end
    check_eq("t1_wrap", 32'(phasecounter), 32'h01);
    check_eq("t1_retired", 32'(retired), 32'd1);

    // 2: three-cycle MEM stall
    tick(); tick(); tick();
    mem_busy = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2_hold%0d", i), 32'(phasecounter), 32'h08);
      check_eq($sformatf("t2_nolatch%0d", i), 32'(strobes()), 32'h0);
      if (i < 2) tick();
      else begin @(posedge clock); #1; end
    end
    mem_busy = 1'b0; #1;
    check_eq("t2_release_latch", 32'(strobes()), 32'h8);
    tick();
    check_eq("t2_wb", 32'(phasecounter), 32'h10);
    tick();
    check_eq("t2_retired", 32'(retired), 32'd2);

    // 3: flush in EX bubbles IF and ID; flush in ID is ignored
    tick(); tick();
    flush_req = 1'b1;
    check_eq("t3_ex_nobubble", 32'({bubble_idex, bubble_ifid}), 32'h0);
    tick(); flush_req = 1'b0;
    tick(); tick();
    check_eq("t3_if_latch", 32'(latch_ifid), 32'h1);
    check_eq("t3_if_bubble", 32'({bubble_idex, bubble_ifid}), 32'h1);
    tick();
    check_eq("t3_id_bubble", 32'({bubble_idex, bubble_ifid}), 32'h2);
    tick();
    check_eq("t3_ex_clear", 32'({bubble_idex, bubble_ifid}), 32'h0);
    tick(); tick(); tick();
    tick(); flush_req = 1'b1;
    tick(); flush_req = 1'b0;
    tick(); tick(); tick();
    check_eq("t3_idflush_if", 32'({bubble_idex, bubble_ifid}), 32'h0);
    tick();
    check_eq("t3_idflush_id", 32'({bubble_idex, bubble_ifid}), 32'h0);
    check_eq("t3_retired", 32'(retired), 32'd5);

    // 4: single step, then start+halt_req together at WB
    step_en = 1'b1;
    tick(); tick(); tick();
    check_eq("t4_wb_running", 32'(running), 32'h1);
    tick();
    check_eq("t4_halted", 32'(halted), 32'h1);
    check_eq("t4_phase", 32'(phasecounter), 32'h01);
    check_eq("t4_retired6", 32'(retired), 32'd6);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_step_run%0d", i), 32'(running), 32'h1);
      tick();
    end
    check_eq("t4_step_halted", 32'(halted), 32'h1);
    check_eq("t4_step_phase", 32'(phasecounter), 32'h01);
    check_eq("t4_retired7", 32'(retired), 32'd7);
    step_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("t4_at_wb", 32'(phasecounter), 32'h10);
    halt_req = 1'b1; start = 1'b1;
    tick();
    halt_req = 1'b0; start = 1'b0;
    check_eq("t4_halt_wins", 32'(halted), 32'h1);
    check_eq("t4_halt_phase", 32'(phasecounter), 32'h01);
    check_eq("t4_retired8", 32'(retired), 32'd8);
    tick();
    check_eq("t4_still_halted", 32'(halted), 32'h1);

    // 5: watchdog expiry after 4 stalled cycles
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    mem_busy = 1'b1;
    tick(); tick(); tick();
    check_eq("t5_stall4_run", 32'(running), 32'h1);
    check_eq("t5_stall4_tmo", 32'(stall_timeout), 32'h0);
    check_eq("t5_stall4_phase", 32'(phasecounter), 32'h08);
    tick();
    check_eq("t5_tmo", 32'(stall_timeout), 32'h1);
    check_eq("t5_halted", 32'(halted), 32'h1);
    check_eq("t5_phase", 32'(phasecounter), 32'h01);
    check_eq("t5_retired", 32'(retired), 32'd8);
    mem_busy = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("t5_restart_run", 32'(running), 32'h1);
    check_eq("t5_restart_tmo", 32'(stall_timeout), 32'h0);

    // 6: reset during EX, then retired saturation
    tick(); tick();
    check_eq("t6_ex", 32'(phasecounter), 32'h04);
    reset = 1'b1;
    tick();
    check_reset_state("t6_rst");
    reset = 1'b0;
    tick();
    check_eq("t6_post_phase", 32'(phasecounter), 32'h01);
    force dut.retired_reg = 16'hFFFE;
    #1;
    release dut.retired_reg;
    #1;
    check_eq("t6_forced", 32'(retired), 32'hFFFE);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check_eq("t6_sat1", 32'(retired), 32'hFFFF);
    tick(); tick(); tick(); tick(); tick();
    check_eq("t6_sat2", 32'(retired), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
